alarm_unit: RTL and testbench

//  Alarm stage downstream of the time-of-day counters: consumes the running
//  sec/min/hour values, holds a user-set alarm time, and drives a buzzer.

---
 rtl/alarm_unit.sv | 181 ++++++++++++++++++
 tb/tb_alarm_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_unit.sv
// Alarm stage: holds a user-set alarm time, detects a match against the
// running time-of-day, and sequences ringing, snooze and dismiss.
module alarm_unit #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] sec1,
    input  logic [4:0] sec10,
    input  logic [4:0] min1,
    input  logic [4:0] min10,
    input  logic [4:0] hou,
    input  logic       set_btn,
    input  logic       inc_btn,
    input  logic       snz_btn,
    output logic [4:0] alm_hou,
    output logic [2:0] alm_min10,
    output logic [3:0] alm_min1,
    output logic [1:0] setting,
    output logic       armed,
    output logic       buzzer
);

    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HR,
        ST_SET_MT,
        ST_SET_MO,
        ST_RING,
        ST_SNOOZE
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic          r_set_q,     r_inc_q,     r_snz_q;
    logic          r_match_q;
    logic [4:0]    r_alm_hou,   w_alm_hou_nxt;
    logic [2:0]    r_alm_min10, w_alm_min10_nxt;
    logic [3:0]    r_alm_min1,  w_alm_min1_nxt;
    logic          r_armed,     w_armed_nxt;
    logic [RW-1:0] r_ring_cnt,  w_ring_cnt_nxt;
    logic [SW-1:0] r_snz_cnt,   w_snz_cnt_nxt;

    logic w_set_p, w_inc_p, w_snz_p;
    logic w_match, w_trigger;

    assign w_set_p = set_btn & ~r_set_q;
    assign w_inc_p = inc_btn & ~r_inc_q;
    assign w_snz_p = snz_btn & ~r_snz_q;

    assign w_match = (hou   == r_alm_hou)
                   && (min10 == {2'b00, r_alm_min10})
                   && (min1  == {1'b0, r_alm_min1})
                   && (sec10 == 5'd0)
                   && (sec1  == 5'd0);
    assign w_trigger = w_match & ~r_match_q;

    assign alm_hou   = r_alm_hou;
    assign alm_min10 = r_alm_min10;
    assign alm_min1  = r_alm_min1;
    assign armed     = r_armed;
    assign buzzer    = (r_state == ST_RING);

    // State, alarm time, counters and edge-detect history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_set_q     <= 1'b0;
            r_inc_q     <= 1'b0;
            r_snz_q     <= 1'b0;
            r_match_q   <= 1'b0;
            r_alm_hou   <= '0;
            r_alm_min10 <= '0;
            r_alm_min1  <= '0;
            r_armed     <= 1'b0;
            r_ring_cnt  <= '0;
            r_snz_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_set_q     <= set_btn;
            r_inc_q     <= inc_btn;
            r_snz_q     <= snz_btn;
            r_match_q   <= w_match;
            r_alm_hou   <= w_alm_hou_nxt;
            r_alm_min10 <= w_alm_min10_nxt;
            r_alm_min1  <= w_alm_min1_nxt;
            r_armed     <= w_armed_nxt;
            r_ring_cnt  <= w_ring_cnt_nxt;
            r_snz_cnt   <= w_snz_cnt_nxt;
        end
    end

    // Next-state logic; button priority is set > snz > tick > inc.
    always_comb begin
        w_state_nxt     = r_state;
        w_alm_hou_nxt   = r_alm_hou;
        w_alm_min10_nxt = r_alm_min10;
        w_alm_min1_nxt  = r_alm_min1;
        w_armed_nxt     = r_armed;
        w_ring_cnt_nxt  = r_ring_cnt;
        w_snz_cnt_nxt   = r_snz_cnt;
        setting         = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_set_p) begin
                    w_state_nxt = ST_SET_HR;
                end else if (w_snz_p) begin
                    w_armed_nxt = ~r_armed;
                end else if (w_trigger && r_armed) begin
                    w_state_nxt    = ST_RING;
                    w_ring_cnt_nxt = '0;
                end
            end
            ST_SET_HR: begin
                setting = 2'd1;
                if (w_set_p) begin
                    w_state_nxt = ST_SET_MT;
                end else if (w_inc_p) begin
                    w_alm_hou_nxt = (r_alm_hou == 5'd23) ? 5'd0 : r_alm_hou + 5'd1;
                end
            end
            ST_SET_MT: begin
                setting = 2'd2;
                if (w_set_p) begin
                    w_state_nxt = ST_SET_MO;
                end else if (w_inc_p) begin
                    w_alm_min10_nxt = (r_alm_min10 == 3'd5) ? 3'd0 : r_alm_min10 + 3'd1;
                end
            end
            ST_SET_MO: begin
                setting = 2'd3;
                if (w_set_p) begin
                    w_state_nxt = ST_IDLE;
                    w_armed_nxt = 1'b1;
                end else if (w_inc_p) begin
                    w_alm_min1_nxt = (r_alm_min1 == 4'd9) ? 4'd0 : r_alm_min1 + 4'd1;
                end
            end
            ST_RING: begin
                if (w_set_p) begin
                    w_state_nxt = ST_IDLE;
                    w_armed_nxt = 1'b0;
                end else if (w_snz_p) begin
                    w_state_nxt   = ST_SNOOZE;
                    w_snz_cnt_nxt = '0;
                end else if (tick_1hz) begin
                    if (r_ring_cnt == RING_LAST) begin
                        w_state_nxt    = ST_IDLE;
                        w_ring_cnt_nxt = '0;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt + 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (w_set_p) begin
                    w_state_nxt = ST_IDLE;
                    w_armed_nxt = 1'b0;
                end else if (tick_1hz) begin
                    if (r_snz_cnt == SNZ_LAST) begin
                        w_state_nxt    = ST_RING;
                        w_ring_cnt_nxt = '0;
                        w_snz_cnt_nxt  = '0;
                    end else begin
                        w_snz_cnt_nxt = r_snz_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: setting, ringing, snooze, dismiss, wraps, reset.
module tb_alarm_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [4:0] sec1, sec10, min1, min10, hou;
    logic       set_btn, inc_btn, snz_btn;
    logic [4:0] alm_hou;
    logic [2:0] alm_min10;
    logic [3:0] alm_min1;
    logic [1:0] setting;
    logic       armed;
    logic       buzzer;

    int n_vec = 0;
    int n_err = 0;

    alarm_unit #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10), .hou(hou),
        .set_btn(set_btn), .inc_btn(inc_btn), .snz_btn(snz_btn),
        .alm_hou(alm_hou), .alm_min10(alm_min10), .alm_min1(alm_min1),
        .setting(setting), .armed(armed), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m10, input int m1, input int s10, input int s1);
        hou = 5'(h); min10 = 5'(m10); min1 = 5'(m1); sec10 = 5'(s10); sec1 = 5'(s1);
    endtask

    task automatic press_set();
        set_btn = 1'b1; cyc(); set_btn = 1'b0; cyc();
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; cyc(); inc_btn = 1'b0; cyc();
    endtask

    task automatic press_snz();
        snz_btn = 1'b1; cyc(); snz_btn = 1'b0; cyc();
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_1hz = 1'b0;
        set_btn = 1'b0; inc_btn = 1'b0; snz_btn = 1'b0;
        set_time(12, 0, 0, 0, 1);
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL reset_buzzer got=%0b exp=0", buzzer); end
        n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed got=%0b exp=0", armed); end
        n_vec++; if (setting !== 2'd0) begin n_err++; $display("FAIL reset_setting got=%0d exp=0", setting); end
        n_vec++; if ({alm_hou, alm_min10, alm_min1} !== 12'd0) begin
            n_err++; $display("FAIL reset_alm got=%0d:%0d%0d exp=0:00", alm_hou, alm_min10, alm_min1);
        end
    endtask

    task automatic test_set_alarm();
        press_set();
        n_vec++; if (setting !== 2'd1) begin n_err++; $display("FAIL set_hr_mode got=%0d exp=1", setting); end
        repeat (7) press_inc();
        press_set();
        n_vec++; if (setting !== 2'd2) begin n_err++; $display("FAIL set_mt_mode got=%0d exp=2", setting); end
        repeat (3) press_inc();
        press_set();
        n_vec++; if (setting !== 2'd3) begin n_err++; $display("FAIL set_mo_mode got=%0d exp=3", setting); end
        repeat (5) press_inc();
        n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL armed_before_exit got=%0b exp=0", armed); end
        press_set();
        n_vec++; if ({alm_hou, alm_min10, alm_min1} !== {5'd7, 3'd3, 4'd5}) begin
            n_err++; $display("FAIL alarm_0735 got=%0d:%0d%0d exp=7:35", alm_hou, alm_min10, alm_min1);
        end
        n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL armed_after_set got=%0b exp=1", armed); end
        n_vec++; if (setting !== 2'd0) begin n_err++; $display("FAIL setting_idle got=%0d exp=0", setting); end
    endtask

    task automatic test_ring_timeout();
        set_time(7, 3, 4, 5, 9);
        repeat (3) cyc();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL pre_match_buzzer got=%0b exp=0", buzzer); end
        set_time(7, 3, 5, 0, 0);
        cyc();
        n_vec++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL ring_start got=%0b exp=1", buzzer); end
        repeat (20) cyc();
        n_vec++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL ring_hold got=%0b exp=1", buzzer); end
        repeat (59) do_tick();
        n_vec++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL ring_59_ticks got=%0b exp=1", buzzer); end
        do_tick();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL ring_timeout got=%0b exp=0", buzzer); end
        n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL armed_after_timeout got=%0b exp=1", armed); end
        repeat (10) cyc();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL no_retrigger got=%0b exp=0", buzzer); end
        press_snz();
        n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL snz_disarm got=%0b exp=0", armed); end
        press_snz();
        n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL snz_rearm got=%0b exp=1", armed); end
    endtask

    task automatic test_snooze();
        set_time(7, 3, 5, 0, 1);
        cyc();
        set_time(7, 3, 5, 0, 0);
        cyc();
        n_vec++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL refire got=%0b exp=1", buzzer); end
        snz_btn = 1'b1;
        cyc();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL snooze_enter got=%0b exp=0", buzzer); end
        snz_btn = 1'b0;
        cyc();
        repeat (299) do_tick();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL snooze_299 got=%0b exp=0", buzzer); end
        do_tick();
        n_vec++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL snooze_reringing got=%0b exp=1", buzzer); end
    endtask

    task automatic test_dismiss();
        set_btn = 1'b1; snz_btn = 1'b1;
        cyc();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL dismiss_buzzer got=%0b exp=0", buzzer); end
        n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL dismiss_armed got=%0b exp=0", armed); end
        n_vec++; if (setting !== 2'd0) begin n_err++; $display("FAIL dismiss_setting got=%0d exp=0", setting); end
        set_btn = 1'b0; snz_btn = 1'b0;
        cyc();
        set_time(7, 3, 5, 0, 1);
        cyc();
        set_time(7, 3, 5, 0, 0);
        repeat (3) cyc();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL disarmed_match got=%0b exp=0", buzzer); end
    endtask

    task automatic test_wraps();
        press_set();
        repeat (16) press_inc();
        n_vec++; if (alm_hou !== 5'd23) begin n_err++; $display("FAIL hour_23 got=%0d exp=23", alm_hou); end
        press_inc();
        n_vec++; if (alm_hou !== 5'd0) begin n_err++; $display("FAIL hour_wrap got=%0d exp=0", alm_hou); end
        set_btn = 1'b1; inc_btn = 1'b1;
        cyc();
        n_vec++; if (setting !== 2'd2) begin n_err++; $display("FAIL set_inc_advance got=%0d exp=2", setting); end
        n_vec++; if ({alm_hou, alm_min10} !== {5'd0, 3'd3}) begin
            n_err++; $display("FAIL set_inc_noinc got=%0d/%0d exp=0/3", alm_hou, alm_min10);
        end
        set_btn = 1'b0; inc_btn = 1'b0;
        cyc();
        repeat (2) press_inc();
        n_vec++; if (alm_min10 !== 3'd5) begin n_err++; $display("FAIL min10_5 got=%0d exp=5", alm_min10); end
        press_inc();
        n_vec++; if (alm_min10 !== 3'd0) begin n_err++; $display("FAIL min10_wrap got=%0d exp=0", alm_min10); end
        press_set();
        repeat (4) press_inc();
        n_vec++; if (alm_min1 !== 4'd9) begin n_err++; $display("FAIL min1_9 got=%0d exp=9", alm_min1); end
        press_inc();
        n_vec++; if (alm_min1 !== 4'd0) begin n_err++; $display("FAIL min1_wrap got=%0d exp=0", alm_min1); end
        press_set();
        n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL wrap_armed got=%0b exp=1", armed); end
    endtask

    task automatic test_reset_mid_ring();
        press_set();
        press_inc();
        press_set();
        press_set();
        press_set();
        n_vec++; if ({alm_hou, alm_min10, alm_min1} !== {5'd1, 3'd0, 4'd0}) begin
            n_err++; $display("FAIL alarm_0100 got=%0d:%0d%0d exp=1:00", alm_hou, alm_min10, alm_min1);
        end
        set_time(0, 5, 9, 5, 9);
        cyc();
        set_time(1, 0, 0, 0, 0);
        cyc();
        n_vec++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL ring_0100 got=%0b exp=1", buzzer); end
        repeat (3) do_tick();
        reset = 1'b1;
        cyc();
        n_vec++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL rst_ring_buzzer got=%0b exp=0", buzzer); end
        n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL rst_ring_armed got=%0b exp=0", armed); end
        n_vec++; if (setting !== 2'd0) begin n_err++; $display("FAIL rst_ring_setting got=%0d exp=0", setting); end
        n_vec++; if ({alm_hou, alm_min10, alm_min1} !== 12'd0) begin
            n_err++; $display("FAIL rst_ring_alm got=%0d:%0d%0d exp=0:00", alm_hou, alm_min10, alm_min1);
        end
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_set_alarm();
        test_ring_timeout();
        test_snooze();
        test_dismiss();
        test_wraps();
        test_reset_mid_ring();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
